// File: rtl/mem_access_unit_pkg.sv
// Shared encodings and helpers for the data-memory access unit.
// Sizes, FSM states, the alignment check and the store lane merge.
package mem_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_ILL  = 2'b11;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_RD     = 3'd1;
    localparam state_t ST_WR     = 3'd2;
    localparam state_t ST_RMW_RD = 3'd3;
    localparam state_t ST_RESP   = 3'd4;

    function automatic logic access_err(input logic [1:0] size, input logic [1:0] offset);
        logic err;
        case (size)
            SZ_BYTE: err = 1'b0;
            SZ_HALF: err = offset[0];
            SZ_WORD: err = (offset != 2'b00);
            SZ_ILL:  err = 1'b1;
            default: err = 1'b1;
        endcase
        return err;
    endfunction

    // Replaces the addressed lane of old_word; word size passes wdata straight through.
    function automatic logic [31:0] lane_merge(input logic [31:0] old_word,
                                               input logic [31:0] wdata,
                                               input logic [1:0]  size,
                                               input logic [1:0]  offset);
        logic [31:0] merged;
        merged = old_word;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]     = wdata[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = wdata[15:0];
            default: merged = wdata;
        endcase
        return merged;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Request/response handshake plus the dataMemory port of the access unit.
// slave = the access unit, master = MEM stage and memory together.
interface mem_access_unit_if #(
    parameter int ADDR_WIDTH = 32
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [1:0]            req_size;
    logic                  req_signed;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [31:0]           req_wdata;

    logic                  resp_valid;
    logic                  resp_ready;
    logic [31:0]           resp_rdata;
    logic                  resp_err;

    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [31:0]           mem_wd;
    logic [31:0]           mem_rd;

    modport slave (
        input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        output req_ready,
        output resp_valid, resp_rdata, resp_err,
        input  resp_ready,
        output mem_we, mem_a, mem_wd,
        input  mem_rd
    );

    modport master (
        output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
        input  req_ready,
        input  resp_valid, resp_rdata, resp_err,
        output resp_ready,
        input  mem_we, mem_a, mem_wd,
        output mem_rd
    );

endinterface

// File: rtl/mem_lane_extract.sv
// Little-endian lane select with sign/zero extension for loads.
// Pure combinational so the pipeline's load alignment can reuse it.
module mem_lane_extract
    import mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  offset_i,
    input  logic        signed_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = word_i[{offset_i, 3'b000} +: 8];
    assign half_sel = word_i[{offset_i[1], 4'b0000} +: 16];

    always_comb begin
        data_o = word_i;
        case (size_i)
            SZ_BYTE: data_o = {{24{signed_i & byte_sel[7]}}, byte_sel};
            SZ_HALF: data_o = {{16{signed_i & half_sel[15]}}, half_sel};
            default: data_o = word_i;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store initiator for a word-only dataMemory: sub-word stores via
// read-modify-write, sub-word loads via lane extract, one response per request.
module mem_access_unit
    import mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    mem_access_unit_if.slave bus
);

    state_t                state_q, state_d;
    logic                  we_q, we_d;
    logic [1:0]            size_q, size_d;
    logic                  signed_q, signed_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [31:0]           old_q, old_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  err_q, err_d;

    logic [31:0]           load_data;
    logic                  mem_cycle;

    mem_lane_extract u_extract (
        .word_i   (bus.mem_rd),
        .size_i   (size_q),
        .offset_i (addr_q[1:0]),
        .signed_i (signed_q),
        .data_o   (load_data)
    );

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        size_d   = size_q;
        signed_d = signed_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        old_d    = old_q;
        rdata_d  = rdata_q;
        err_d    = err_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.req_valid) begin
                    we_d     = bus.req_we;
                    size_d   = bus.req_size;
                    signed_d = bus.req_signed;
                    addr_d   = bus.req_addr;
                    wdata_d  = bus.req_wdata;
                    rdata_d  = '0;
                    err_d    = access_err(bus.req_size, bus.req_addr[1:0]);
                    if (err_d)
                        state_d = ST_RESP;
                    else if (!bus.req_we)
                        state_d = ST_RD;
                    else if (bus.req_size == SZ_WORD)
                        state_d = ST_WR;
                    else
                        state_d = ST_RMW_RD;
                end
            end
            ST_RD: begin
                rdata_d = load_data;
                state_d = ST_RESP;
            end
            ST_RMW_RD: begin
                old_d   = bus.mem_rd;
                state_d = ST_WR;
            end
            ST_WR: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                if (bus.resp_ready)
                    state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            we_q     <= 1'b0;
            size_q   <= SZ_BYTE;
            signed_q <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            old_q    <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            size_q   <= size_d;
            signed_q <= signed_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            old_q    <= old_d;
            rdata_q  <= rdata_d;
            err_q    <= err_d;
        end
    end

    // Memory strobes decode straight from state so reset kills a pending write at once.
    assign mem_cycle      = (state_q == ST_RD) || (state_q == ST_WR) || (state_q == ST_RMW_RD);
    assign bus.mem_we     = (state_q == ST_WR);
    assign bus.mem_a      = mem_cycle ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign bus.mem_wd     = (state_q == ST_WR) ? lane_merge(old_q, wdata_q, size_q, addr_q[1:0]) : '0;

    assign bus.req_ready  = (state_q == ST_IDLE);
    assign bus.resp_valid = (state_q == ST_RESP);
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    logic unused_we;
    assign unused_we = we_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit with a 16-word dataMemory model.
// Expected values are hand-computed from the little-endian lane rules.
module tb_mem_access_unit;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    mem_access_unit_if #(.ADDR_WIDTH(32)) bus ();

    mem_access_unit #(.ADDR_WIDTH(32)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [31:0] dmem [0:15];
    assign bus.mem_rd = dmem[bus.mem_a[5:2]];
    always @(posedge clk) begin
        if (bus.mem_we)
            dmem[bus.mem_a[5:2]] <= bus.mem_wd;
    end

    // Counts write and read strobes so each test can compare before/after deltas.
    int          we_cnt;
    int          rd_cnt;
    logic [31:0] last_wd;
    logic [31:0] last_a;
    initial begin
        we_cnt  = 0;
        rd_cnt  = 0;
        last_wd = '0;
        last_a  = '0;
        forever begin
            @(negedge clk);
            if (rst_n && bus.mem_we) begin
                we_cnt++;
                last_wd = bus.mem_wd;
                last_a  = bus.mem_a;
            end
            if (rst_n && !bus.mem_we && bus.mem_a != 32'd0)
                rd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end else begin
            $display("ok   %s = %08h", tag, got);
        end
    endtask

    // Starts #1 after a rising edge; returns once resp_valid is seen (or times out).
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err, output int lat);
        bus.req_valid  = 1'b1;
        bus.req_we     = we;
        bus.req_size   = size;
        bus.req_signed = sgn;
        bus.req_addr   = addr;
        bus.req_wdata  = wdata;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (!bus.resp_valid && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        $display("txn we=%0b size=%0d sgn=%0b addr=%08h wdata=%08h -> rdata=%08h err=%0b lat=%0d",
                 we, size, sgn, addr, wdata, rdata, err, lat);
    endtask

    task automatic consume();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;
    int          we0;
    int          rd0;
    logic [31:0] held;

    initial begin
        checks   = 0;
        failures = 0;
        rst_n          = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = '0;
        bus.req_wdata  = '0;
        bus.resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_req_ready",  {31'd0, bus.req_ready},  32'd1);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        check("rst_resp_rdata", bus.resp_rdata,          32'd0);
        check("rst_mem_we",     {31'd0, bus.mem_we},     32'd0);
        check("rst_mem_a",      bus.mem_a,               32'd0);

        // Word store then load
        we0 = we_cnt;
        do_req(1'b1, 2'b10, 1'b0, 32'd4, 32'hDEADBEEF, rd, er, lat);
        check("sw_lat",     lat,               32'd2);
        check("sw_err",     {31'd0, er},       32'd0);
        check("sw_rdata",   rd,                32'd0);
        check("sw_we_cnt",  we_cnt - we0,      32'd1);
        check("sw_mem_a",   last_a,            32'd4);
        consume();
        check("sw_ready_after", {31'd0, bus.req_ready}, 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, rd, er, lat);
        check("lw_rdata", rd,         32'hDEADBEEF);
        check("lw_err",   {31'd0, er}, 32'd0);
        check("lw_lat",   lat,        32'd2);
        consume();

        // Sub-word loads
        do_req(1'b0, 2'b00, 1'b1, 32'd7, 32'h0, rd, er, lat);
        check("lb7_signed", rd, 32'hFFFFFFDE);
        consume();
        do_req(1'b0, 2'b00, 1'b0, 32'd4, 32'h0, rd, er, lat);
        check("lbu4", rd, 32'h000000EF);
        consume();
        do_req(1'b0, 2'b01, 1'b1, 32'd6, 32'h0, rd, er, lat);
        check("lh6_signed", rd, 32'hFFFFDEAD);
        consume();
        do_req(1'b0, 2'b01, 1'b0, 32'd6, 32'h0, rd, er, lat);
        check("lhu6", rd, 32'h0000DEAD);
        consume();
        do_req(1'b0, 2'b00, 1'b1, 32'd5, 32'h0, rd, er, lat);
        check("lb5_signed", rd, 32'hFFFFFFBE);
        consume();

        // Read-modify-write stores
        do_req(1'b1, 2'b10, 1'b0, 32'd8, 32'h11223344, rd, er, lat);
        consume();
        we0 = we_cnt;
        rd0 = rd_cnt;
        do_req(1'b1, 2'b00, 1'b0, 32'd9, 32'h000000AA, rd, er, lat);
        check("sb9_lat",    lat,           32'd3);
        check("sb9_wd",     last_wd,       32'h1122AA44);
        check("sb9_a",      last_a,        32'd8);
        check("sb9_we_cnt", we_cnt - we0,  32'd1);
        check("sb9_rd_cnt", rd_cnt - rd0,  32'd1);
        check("sb9_rdata",  rd,            32'd0);
        consume();
        do_req(1'b1, 2'b01, 1'b0, 32'd10, 32'h1234BEEF, rd, er, lat);
        check("sh10_wd", last_wd, 32'hBEEFAA44);
        consume();
        do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd, er, lat);
        check("lw8_after_rmw", rd, 32'hBEEFAA44);
        consume();

        // Error cases: no memory write may occur
        we0 = we_cnt;
        do_req(1'b0, 2'b01, 1'b0, 32'd3, 32'h0, rd, er, lat);
        check("err_h3_err",   {31'd0, er}, 32'd1);
        check("err_h3_rdata", rd,         32'd0);
        consume();
        do_req(1'b0, 2'b10, 1'b0, 32'd6, 32'h0, rd, er, lat);
        check("err_w6_err",   {31'd0, er}, 32'd1);
        check("err_w6_rdata", rd,         32'd0);
        consume();
        do_req(1'b0, 2'b11, 1'b0, 32'd0, 32'h0, rd, er, lat);
        check("err_sz3_err", {31'd0, er}, 32'd1);
        consume();
        do_req(1'b1, 2'b01, 1'b0, 32'd9, 32'hFFFFFFFF, rd, er, lat);
        check("err_sh9_err", {31'd0, er}, 32'd1);
        consume();
        check("err_no_we", we_cnt - we0, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, rd, er, lat);
        check("after_err_err", {31'd0, er}, 32'd0);
        consume();

        // Backpressure
        bus.resp_ready = 1'b0;
        do_req(1'b0, 2'b10, 1'b0, 32'd4, 32'h0, rd, er, lat);
        held = rd;
        check("bp_rdata", held, 32'hDEADBEEF);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            check("bp_valid_hold", {31'd0, bus.resp_valid}, 32'd1);
            check("bp_rdata_hold", bus.resp_rdata,          held);
            check("bp_ready_low",  {31'd0, bus.req_ready},  32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_release_ready", {31'd0, bus.req_ready},  32'd1);
        check("bp_release_valid", {31'd0, bus.resp_valid}, 32'd0);

        // Reset during the WR phase of an RMW store
        bus.req_valid  = 1'b1;
        bus.req_we     = 1'b1;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'd8;
        bus.req_wdata  = 32'h000000FF;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #1;
        check("rmw_in_wr_we", {31'd0, bus.mem_we}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_mid_we", {31'd0, bus.mem_we}, 32'd0);
        check("rst_mid_a",  bus.mem_a,           32'd0);
        check("rst_mid_wd", bus.mem_wd,          32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_word8_kept",  dmem[2],                 32'hBEEFAA44);
        check("rst_post_ready",  {31'd0, bus.req_ready},  32'd1);
        check("rst_post_valid",  {31'd0, bus.resp_valid}, 32'd0);
        do_req(1'b0, 2'b10, 1'b0, 32'd8, 32'h0, rd, er, lat);
        check("rst_post_lw8", rd, 32'hBEEFAA44);
        consume();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
Initiator side of the data memory port. It takes load/store requests from the MEM stage over a valid/ready handshake and drives dataMemory (clk, we, a, wd, rd). dataMemory holds word-wide data only. This block adds byte and halfword access: stores use read-modify-write and loads use extract-and-extend. It also flags misaligned and illegal accesses and returns one response per request.

Parameters:
ADDR_WIDTH, 32, width of the byte address on the request and memory sides.

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
req_valid  in  1  request present.
req_ready  out  1  unit can accept a request.
req_we  in  1  1 = store, 0 = load.
req_size  in  2  00 byte, 01 half, 10 word, 11 illegal.
req_signed  in  1  sign-extend load data; ignored for stores.
req_addr  in  ADDR_WIDTH  byte address.
req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
resp_valid  out  1  response present.
resp_ready  in  1  consumer takes the response.
resp_rdata  out  32  load result, extended; 0 for stores and errors.
resp_err  out  1  misaligned or illegal size.
mem_we  out  1  to dataMemory we.
mem_a  out  ADDR_WIDTH  to dataMemory a; always word-aligned (low 2 bits 0).
mem_wd  out  32  to dataMemory wd.
mem_rd  in  32  from dataMemory rd (combinational read of mem_a).

Behaviour:
- States: IDLE, RD, WR, RMW_RD, RESP.
- req_ready = (state == IDLE). A request is accepted on the clk edge where req_valid and req_ready are both 1. All request fields are registered at acceptance.
- Error check at acceptance:
  - err when size = 11, or half with addr[0] = 1, or word with addr[1:0] != 0.
  - On err go to RESP with resp_err = 1 and resp_rdata = 0. No memory cycle is issued (mem_we stays 0).
- Load path: IDLE -> RD -> RESP.
  - In RD, drive mem_a = {addr[ADDR_WIDTH-1:2], 2'b00} and mem_we = 0.
  - Capture mem_rd at the end of RD.
  - Latency: resp_valid rises 2 cycles after acceptance.
- Lane selection is little-endian.
  - Byte lane = addr[1:0], bits [8*lane+7 : 8*lane].
  - Half lane = addr[1], bits [16*addr[1]+15 : 16*addr[1]].
  - Zero-extend when req_signed = 0, sign-extend when 1.
- Word store: IDLE -> WR -> RESP.
  - In WR, mem_we = 1, mem_a aligned, mem_wd = req_wdata. The write lands on the clk edge ending WR.
- Sub-word store: IDLE -> RMW_RD -> WR -> RESP.
  - RMW_RD captures the old word from mem_rd with mem_we = 0.
  - WR writes the old word with only the selected byte/half lane replaced by req_wdata[7:0] or [15:0].
  - Latency 3 cycles to resp_valid.
- mem_we = 1 only in WR. mem_wd = 0 and mem_a = 0 outside RD, WR and RMW_RD.
- RESP:
  - resp_valid = 1. resp_rdata and resp_err stay stable until resp_ready = 1.
  - That edge returns to IDLE. A new request can be accepted no earlier than the next cycle (no same-cycle turnaround).
- Stores do not change resp_rdata (it reads 0). Back-to-back requests to the same address see the earlier write because it completes before RESP.
- Reset (asynchronous, any state, including mid-RMW):
  - state = IDLE, so req_ready = 1 once reset is released.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - mem_we = 0 immediately, mem_a = 0, mem_wd = 0.
  - The request in flight is dropped without a response. A partial RMW never writes.
- Address bits above ADDR_WIDTH do not exist. No wrap handling is needed; the address is passed through as-is.

Decomposition:
- Shared package mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD/SZ_ILL, the state encoding, and function lane_merge(old, wdata, size, offset).
- One natural sub-module, mem_lane_extract: a combinational lane select plus sign/zero extend, reusable by the pipeline's load alignment.
- All other logic lives in a single FSM file.

Test Plan:
- Word store then load: store addr 4, size 10, wdata 32'hDEADBEEF. Expect mem_we high for exactly 1 cycle with mem_a = 4, and a response after 2 cycles. Load addr 4 then returns resp_rdata = 32'hDEADBEEF, resp_err = 0.
- Byte load sign/zero: with word 4 = 32'hDEADBEEF, load byte addr 7 signed -> 32'hFFFFFFDE. Load byte addr 4 unsigned -> 32'h000000EF. Load half addr 6 signed -> 32'hFFFFDEAD.
- RMW store: with word 8 = 32'h11223344, store byte addr 9, wdata 32'h000000AA. Expect RMW_RD then WR with mem_wd = 32'h1122AA44, and a response 3 cycles after acceptance.
- Errors: half at addr 3 and word at addr 6 each give resp_err = 1 and resp_rdata = 0. size 11 also gives resp_err = 1. mem_we never asserts in any of these cases.
- Backpressure: hold resp_ready = 0 for 5 cycles. resp_valid and resp_rdata stay stable and req_ready stays 0. Release resp_ready, and req_ready = 1 the next cycle.
- Reset during WR of an RMW store: mem_we drops at once and word 8 keeps its old value. After rst_n rises, req_ready = 1 and resp_valid = 0.
